// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path constants and the aggregator state type.
package eth_pkg;

    localparam int unsigned RMII_W    = 2;
    localparam int unsigned FCS_BITS  = 32;
    localparam int unsigned AGG_OUT_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } agg_state_t;

endpackage

// File: rtl/word_holdback.sv
// HOLD-deep word delay line: a push while full displaces the oldest word.
// HOLD=0 is a plain passthrough of push/word.
module word_holdback #(
    parameter int unsigned W    = 32,
    parameter int unsigned HOLD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         flush_i,
    input  logic [W-1:0] word_i,
    output logic         pop_valid_c,
    output logic [W-1:0] pop_word_c
);

    if (HOLD == 0) begin : g_pass
        assign pop_valid_c = push_i;
        assign pop_word_c  = word_i;
    end else begin : g_line
        localparam int unsigned CW = $clog2(HOLD + 1);

        logic [W-1:0]  line_q [HOLD];
        logic [W-1:0]  line_d [HOLD];
        logic [CW-1:0] count_q, count_d;

        // Index 0 is the newest entry; the oldest valid one sits at count-1.
        always_comb begin
            line_d      = line_q;
            count_d     = count_q;
            pop_valid_c = 1'b0;
            pop_word_c  = line_q[HOLD-1];
            if (flush_i) begin
                count_d = '0;
            end else if (push_i) begin
                if (count_q == CW'(HOLD)) begin
                    pop_valid_c = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                for (int i = HOLD - 1; i > 0; i--) begin
                    line_d[i] = line_q[i-1];
                end
                line_d[0] = word_i;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count_q <= '0;
                for (int i = 0; i < HOLD; i++) begin
                    line_q[i] <= '0;
                end
            end else begin
                count_q <= count_d;
                line_q  <= line_d;
            end
        end
    end

endmodule

// File: rtl/word_aggregate.sv
// Packs narrow beats into OUT_W words, withholds the trailing HOLD words of
// each frame and reports EOF. Optional stats: define WORD_AGGREGATE_STATS_EN.
module word_aggregate
    import eth_pkg::*;
#(
    parameter int unsigned IN_W  = RMII_W,
    parameter int unsigned OUT_W = AGG_OUT_W,
    parameter int unsigned HOLD  = FCS_BITS / AGG_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       axiiv,
    input  logic [IN_W-1:0]            axiid,
    output logic                       axiov,
    output logic [OUT_W-1:0]           axiod,
    output logic                       axioeof,
    output logic [$clog2(OUT_W)-1:0]   axioresid,
`ifdef WORD_AGGREGATE_STATS_EN
    output logic [15:0]                frame_cnt,
    output logic [15:0]                short_cnt,
    output logic [31:0]                word_cnt,
`endif
    output logic                       axioshort
);

    localparam int unsigned BEATS = OUT_W / IN_W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RW    = $clog2(OUT_W);

    agg_state_t        state_q, state_d;
    logic [OUT_W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [15:0]       words_q, words_d;
    logic              axiov_q, axioeof_q, axioeof_d, axioshort_q, axioshort_d;
    logic [OUT_W-1:0]  axiod_q;
    logic [RW-1:0]     axioresid_q, axioresid_d;
    logic              push, flush, pop_valid;
    logic [OUT_W-1:0]  pop_word;

    word_holdback #(
        .W    (OUT_W),
        .HOLD (HOLD)
    ) u_holdback (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .flush_i     (flush),
        .word_i      (shreg_d),
        .pop_valid_c (pop_valid),
        .pop_word_c  (pop_word)
    );

    // Beats are taken in either state; a low cycle in FRAME closes the frame.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        beat_d      = beat_q;
        words_d     = words_q;
        push        = 1'b0;
        flush       = 1'b0;
        axioeof_d   = 1'b0;
        axioresid_d = axioresid_q;
        axioshort_d = axioshort_q;
        if (axiiv) begin
            state_d = FRAME;
            shreg_d = {shreg_q[OUT_W-IN_W-1:0], axiid};
            if (beat_q == BW'(BEATS - 1)) begin
                beat_d = '0;
                push   = 1'b1;
                if (words_q != 16'hFFFF) begin
                    words_d = words_q + 16'd1;
                end
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end else if (state_q == FRAME) begin
            state_d     = IDLE;
            flush       = 1'b1;
            shreg_d     = '0;
            beat_d      = '0;
            words_d     = '0;
            axioeof_d   = 1'b1;
            axioresid_d = RW'(32'(beat_q) * IN_W);
            axioshort_d = (words_q <= 16'(HOLD));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            beat_q      <= '0;
            words_q     <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
            axioeof_q   <= 1'b0;
            axioresid_q <= '0;
            axioshort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            beat_q      <= beat_d;
            words_q     <= words_d;
            axiov_q     <= pop_valid;
            axiod_q     <= pop_valid ? pop_word : axiod_q;
            axioeof_q   <= axioeof_d;
            axioresid_q <= axioresid_d;
            axioshort_q <= axioshort_d;
        end
    end

    assign axiov     = axiov_q;
    assign axiod     = axiod_q;
    assign axioeof   = axioeof_q;
    assign axioresid = axioresid_q;
    assign axioshort = axioshort_q;

`ifdef WORD_AGGREGATE_STATS_EN
    logic [15:0] frame_cnt_q, short_cnt_q;
    logic [31:0] word_cnt_q;

    // Counts advance on the same edge that raises axioeof/axiov.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            short_cnt_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (axioeof_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (axioeof_d && axioshort_d) begin
                short_cnt_q <= short_cnt_q + 16'd1;
            end
            if (pop_valid) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign short_cnt = short_cnt_q;
    assign word_cnt  = word_cnt_q;
`endif

endmodule

// File: tb/tb_word_aggregate.sv
// Directed bench for word_aggregate at default parameters.
module tb_word_aggregate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [31:0] axiod;
    logic        axioeof;
    logic [4:0]  axioresid;
    logic        axioshort;
`ifdef WORD_AGGREGATE_STATS_EN
    logic [15:0] frame_cnt, short_cnt;
    logic [31:0] word_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] wq[$];
    int          eres[$];
    logic        esh[$];
    logic        eov[$];

    word_aggregate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .axiiv     (axiiv),
        .axiid     (axiid),
        .axiov     (axiov),
        .axiod     (axiod),
        .axioeof   (axioeof),
        .axioresid (axioresid),
`ifdef WORD_AGGREGATE_STATS_EN
        .frame_cnt (frame_cnt),
        .short_cnt (short_cnt),
        .word_cnt  (word_cnt),
`endif
        .axioshort (axioshort)
    );

    always #5 clk = ~clk;

    // Log output pulses mid-cycle; axiiv here is the beat presented alongside.
    always @(negedge clk) begin
        if (axiov) wq.push_back(axiod);
        if (axioeof) begin
            eres.push_back(int'(axioresid));
            esh.push_back(axioshort);
            eov.push_back(axiiv);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        axiiv = v;
        axiid = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    task automatic clear_logs();
        wq.delete();
        eres.delete();
        esh.delete();
        eov.delete();
    endtask

    function automatic logic [1:0] dibit(input logic [31:0] w, input int k);
        return w[31-2*k -: 2];
    endfunction

    // n beats taken MSB-first from w0..w4, then the one-cycle gap.
    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4, input int n);
        logic [31:0] w[5];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, dibit(w[i/16], i % 16));
        end
        drive(1'b0, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiod", axiod, 32'd0);
        check("rst_axioeof", 32'(axioeof), 32'd0);
        check("rst_resid", 32'(axioresid), 32'd0);
        check("rst_short", 32'(axioshort), 32'd0);

        // 64-dibit frame: FCS word withheld
        clear_logs();
        send_frame(32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 32'h0, 64);
        idle(3);
        check("f64_nwords", 32'(wq.size()), 32'd3);
        check("f64_w0", wq[0], 32'h11111111);
        check("f64_w1", wq[1], 32'h22222222);
        check("f64_w2", wq[2], 32'h33333333);
        check("f64_neof", 32'(eres.size()), 32'd1);
        check("f64_resid", 32'(eres[0]), 32'd0);
        check("f64_short", 32'(esh[0]), 32'd0);
        check("f64_axiod_hold", axiod, 32'h33333333);

        // 16-dibit frame: one word, all held back
        clear_logs();
        send_frame(32'hAAAAAAAA, 32'h0, 32'h0, 32'h0, 32'h0, 16);
        idle(3);
        check("f16_nwords", 32'(wq.size()), 32'd0);
        check("f16_neof", 32'(eres.size()), 32'd1);
        check("f16_short", 32'(esh[0]), 32'd1);
        check("f16_resid", 32'(eres[0]), 32'd0);

        // 66-dibit frame: two residual beats
        clear_logs();
        send_frame(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'hC0000000, 66);
        idle(3);
        check("f66_nwords", 32'(wq.size()), 32'd3);
        check("f66_w0", wq[0], 32'h01234567);
        check("f66_w1", wq[1], 32'h89ABCDEF);
        check("f66_w2", wq[2], 32'hFEDCBA98);
        check("f66_resid", 32'(eres[0]), 32'd4);
        check("f66_short", 32'(esh[0]), 32'd0);

`ifdef WORD_AGGREGATE_STATS_EN
        check("stat_frames", 32'(frame_cnt), 32'd3);
        check("stat_shorts", 32'(short_cnt), 32'd1);
        check("stat_words", word_cnt, 32'd6);
`endif

        // Back-to-back frames with a single idle cycle
        clear_logs();
        send_frame(32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 32'h0, 64);
        send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 64);
        idle(3);
        check("b2b_nwords", 32'(wq.size()), 32'd6);
        check("b2b_f2w0", wq[3], 32'hA5A5A5A5);
        check("b2b_f2w1", wq[4], 32'h5A5A5A5A);
        check("b2b_neof", 32'(eres.size()), 32'd2);
        check("b2b_eof1_overlap", 32'(eov[0]), 32'd1);
        check("b2b_eof2_idle", 32'(eov[1]), 32'd0);

        // Reset at beat 40; the 23 later beats form a fresh short fragment
        clear_logs();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, dibit(32'h11111111 + 32'(i / 16) * 32'h11111111, i % 16));
            rst_n = (i != 40);
            if (i == 41) begin
                clear_logs();
                check("rst_mid_axiod", axiod, 32'd0);
                check("rst_mid_axiov", 32'(axiov), 32'd0);
            end
        end
        drive(1'b0, 2'b00);
        idle(3);
        check("rst_mid_nwords", 32'(wq.size()), 32'd0);
        check("rst_mid_neof", 32'(eres.size()), 32'd1);
        check("rst_mid_frag_resid", 32'(eres[0]), 32'd14);
        check("rst_mid_frag_short", 32'(esh[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_aggregate.md
# word_aggregate

Parametrised successor to the single-word RMII aggregator in the Ethernet receive path. It packs a frame's narrow input beats (dibits from the PHY/bit-order stage) into OUT_W-bit words and streams every completed word. The last HOLD words of each frame (the FCS) are held back and discarded. An end-of-frame pulse carries the residual bit count and a short-frame flag. It feeds the NAL/packet parser that fills the H.264 decoder's bitstream buffer.

## Interface
- IN_W, default 2: input beat width in bits; must divide OUT_W.
- OUT_W, default 32: output word width in bits.
- HOLD, default 1: trailing words withheld per frame (the FCS); legal range 0–4.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: synchronous, active-low reset.
- axiiv  in  1: input beat valid; high for the whole frame.
- axiid  in  IN_W: input beat.
- axiov  out  1: one-cycle pulse; axiod holds a payload word.
- axiod  out  OUT_W: output word; first beat of the word in bits [OUT_W-1:OUT_W-IN_W].
- axioeof  out  1: one-cycle end-of-frame pulse.
- axioresid  out  $clog2(OUT_W): bits in the trailing partial word; valid with axioeof.
- axioshort  out  1: frame completed ≤ HOLD words; valid with axioeof.

## Operation
- States: IDLE, FRAME.
  - IDLE→FRAME on axiiv=1.
  - FRAME→IDLE on the first cycle axiiv=0.
- A single low cycle of axiiv ends the frame.
- Packing:
  - Each valid beat does shift-left by IN_W and inserts axiid into the LSBs.
  - A beat counter runs 0…OUT_W/IN_W-1. When it wraps, the word is complete.
- Hold-back:
  - Each complete word enters a HOLD-deep delay line.
  - When the line is already full, the word it displaces is emitted on axiov/axiod.
  - HOLD=0: every completed word is emitted directly.
- Frame end, on the FRAME→IDLE transition:
  - Delay-line contents and the partial word are discarded.
  - axioeof=1 for exactly one cycle.
  - axioresid = total frame bits mod OUT_W.
  - axioshort = (completed words ≤ HOLD), with short words counted as not emitted. HOLD=0: axioshort = (completed words = 0).
- Completed-word counter: saturates at 2^16-1. It is used only for axioshort.
- axioeof is never asserted while in IDLE. It fires only once per frame.
- axiod holds its last value when axiov=0. It is never X after reset.
- Reset mid-frame: all state clears and the frame is abandoned. No axiov or axioeof follows for it.

## Timing
- Reset values:
  - axiov=0, axiod=0, axioeof=0, axioresid=0, axioshort=0.
  - State IDLE, all counters 0, delay line empty.
- Latency: the beat that completes word k+HOLD is sampled at cycle t. Word k appears on axiod with axiov=1 at cycle t+1.
- EOF: axiiv is first sampled low at cycle t. axioeof pulses at t+1.
- A new frame may start the cycle after the one-cycle gap. That first beat is accepted while axioeof is high, so EOF and first-beat capture coincide.
- Throughput: one beat per cycle. No backpressure exists. The downstream consumer must accept every axiov pulse.

## Configuration
- WORD_AGGREGATE_STATS_EN defined adds three outputs:
  - frame_cnt out 16: frames ended.
  - short_cnt out 16: frames flagged short.
  - word_cnt out 32: words emitted.
- Stats counters behave as follows:
  - All are wrapping counters, cleared by rst_n.
  - frame_cnt and short_cnt update on the axioeof cycle. word_cnt updates on each axiov cycle.
- Undefined: these ports and their registers do not exist. Core behaviour is identical.

## Structure
- Shared package eth_pkg holds:
  - RMII_W=2.
  - FCS_BITS=32.
  - The agg_state_t enum (IDLE, FRAME).
  - The default OUT_W constant.
- Sub-module word_holdback implements the HOLD-deep word delay line. It has push, flush and pop-valid outputs, and HOLD=0 degenerates to passthrough.
- Packing, counters, FSM and stats live in word_aggregate.

## Test plan
All cases use defaults (IN_W=2, OUT_W=32, HOLD=1) unless stated.
- 64-dibit frame carrying words 0x11111111, 0x22222222, 0x33333333, 0xDEADBEEF → exactly three axiov pulses with 0x11111111, 0x22222222, 0x33333333; axioeof with resid=0, short=0.
- 16-dibit frame → no axiov; axioeof with short=1, resid=0.
- 66-dibit frame → three words; axioeof with resid=4, short=0.
- Two 64-dibit frames separated by one idle cycle → second frame's first word correct; both EOFs present; eof1 overlaps the second frame's first beat.
- rst_n low for one cycle at beat 40 of a 64-dibit frame, axiiv held through → no axiov or axioeof for the abandoned frame.
- With WORD_AGGREGATE_STATS_EN, three frames (64, 16, 66 dibits) → frame_cnt=3, short_cnt=1, word_cnt=6.
